// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

    // Receive sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned CLK_DIV_DEFAULT    = 4;
    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned DATA_BITS_DEFAULT  = 8;

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample timebase: counts 0..CLK_DIV-1 and pulses tick_o on the last count.
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned DivW = cnt_width(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    // Next divider count; clear holds it at zero so the first tick lands CLK_DIV cycles later.
    always_comb begin
        div_d = div_q;
        if (clear_i || (div_q == DivLast)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DivW'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = (div_q == DivLast);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start qualification, mid-bit sampling, one-entry output buffer.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic                 clkIn,
    input  logic                 resetIn,
    input  logic                 rxFilteredIn,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValidOut,
    input  logic                 dataReadyIn,
    output logic                 frameErrOut,
    output logic                 overrunErrOut,
    output logic                 busyOut
);

    localparam int unsigned TickW = cnt_width(OVERSAMPLE);
    localparam int unsigned BitW  = cnt_width(DATA_BITS);

    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitsLast = BitW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;

    logic tick;
    logic commit;
    logic frame_err;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk_i   (clkIn),
        .rst_i   (resetIn),
        .clear_i (state_q == IDLE),
        .tick_o  (tick)
    );

    // Sequencer next state: start qualification at half bit, then full-bit sample spacing.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        commit     = 1'b0;
        frame_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxFilteredIn) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == HalfLast) begin
                        tick_cnt_d = '0;
                        // A line back high by mid start bit was a glitch.
                        state_d    = rxFilteredIn ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FullLast) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxFilteredIn, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BitsLast) begin
                            bit_cnt_d = '0;
                            state_d   = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FullLast) begin
                        tick_cnt_d = '0;
                        if (rxFilteredIn) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            BREAK: begin
                // Wait for the line to return high so a held-low line cannot fake a start.
                if (rxFilteredIn) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output buffer: handshake frees the slot; a commit into a slot that stays full is an overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = frame_err;
        ovr_d   = 1'b0;
        if (valid_q && dataReadyIn) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            if (valid_q && !dataReadyIn) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    // State and buffer registers.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign dataOut       = data_q;
    assign dataValidOut  = valid_q;
    assign frameErrOut   = fe_q;
    assign overrunErrOut = ovr_q;
    assign busyOut       = (state_q != IDLE);

endmodule
